// File: rtl/shift_reg_feeder_if.sv
// Upstream word handshake into the shift-register feeder.
// The feeder sits on the slave side; whoever supplies words uses master.
interface shift_reg_feeder_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic [CNT_W-1:0] shift_count;

  modport master (output in_valid, in_data, in_dir, shift_count, input in_ready);
  modport slave  (input in_valid, in_data, in_dir, shift_count, output in_ready);
endinterface

// File: rtl/shift_reg_feeder.sv
// Serializes a word MSB-first into a 4-bit bidirectional shift register, then shifts it.
// Optional one-word holding buffer: define SHIFT_REG_FEEDER_HOLD_EN.
module shift_reg_feeder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  shift_reg_feeder_if.slave   up,
  output logic                d_in,
  output logic                load,
  output logic                shiftR,
  output logic                busy,
  output logic                done
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             d_in_q, d_in_d, load_q, load_d, shiftR_q, shiftR_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             accept;

`ifdef SHIFT_REG_FEEDER_HOLD_EN
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_word_q, hold_word_d;
  logic             hold_dir_q, hold_dir_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  assign up.in_ready = !reset && !hold_full_q;
`else
  assign up.in_ready = !reset && (state_q == IDLE);
`endif

  assign accept = up.in_valid && up.in_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
`ifdef SHIFT_REG_FEEDER_HOLD_EN
    hold_full_d = hold_full_q;
    hold_word_d = hold_word_q;
    hold_dir_d  = hold_dir_q;
    hold_cnt_d  = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d  = up.in_data;
          dir_d   = up.in_dir;
          cnt_d   = up.shift_count;
          idx_d   = IW'(WIDTH - 1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (idx_q == '0) state_d = (cnt_q != '0) ? SHIFT : DONE;
        else             idx_d   = idx_q - 1'b1;
      end
      SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
`ifdef SHIFT_REG_FEEDER_HOLD_EN
        // Held word goes straight into LOAD; with an empty buffer a word
        // offered during DONE bypasses it for the same back-to-back timing.
        if (hold_full_q) begin
          word_d      = hold_word_q;
          dir_d       = hold_dir_q;
          cnt_d       = hold_cnt_q;
          idx_d       = IW'(WIDTH - 1);
          state_d     = LOAD;
          hold_full_d = 1'b0;
        end else if (accept) begin
          word_d  = up.in_data;
          dir_d   = up.in_dir;
          cnt_d   = up.shift_count;
          idx_d   = IW'(WIDTH - 1);
          state_d = LOAD;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef SHIFT_REG_FEEDER_HOLD_EN
    if (accept && (state_q == LOAD || state_q == SHIFT || (state_q == DONE && hold_full_q))) begin
      hold_full_d = 1'b1;
      hold_word_d = up.in_data;
      hold_dir_d  = up.in_dir;
      hold_cnt_d  = up.shift_count;
    end
`endif
    // Outputs are registered from the next state so they line up with it.
    load_d   = (state_d == LOAD);
    d_in_d   = load_d && word_d[idx_d];
    shiftR_d = (state_d == SHIFT) && dir_d;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      word_q   <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      d_in_q   <= 1'b0;
      load_q   <= 1'b0;
      shiftR_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      d_in_q   <= d_in_d;
      load_q   <= load_d;
      shiftR_q <= shiftR_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef SHIFT_REG_FEEDER_HOLD_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full_q <= 1'b0;
      hold_word_q <= '0;
      hold_dir_q  <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_word_q <= hold_word_d;
      hold_dir_q  <= hold_dir_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end
`endif

  assign d_in   = d_in_q;
  assign load   = load_q;
  assign shiftR = shiftR_q;
  assign busy   = busy_q;
  assign done   = done_q;
endmodule

// File: tb/tb_shift_reg_feeder.sv
// Random and directed stimulus for shift_reg_feeder against a per-cycle trace model.
// Build with SHIFT_REG_FEEDER_HOLD_EN to exercise the holding buffer.
module tb_shift_reg_feeder;
  localparam int W  = 4;
  localparam int CW = 4;
`ifdef SHIFT_REG_FEEDER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic d_in, load, shiftR, busy, done;

  shift_reg_feeder_if #(.WIDTH(W), .CNT_W(CW)) up_if ();

  shift_reg_feeder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .up     (up_if),
    .d_in   (d_in),
    .load   (load),
    .shiftR (shiftR),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs, one entry per cycle: {busy, done, load, shiftR, d_in}.
  logic [4:0]    q[$];
  logic          held;
  logic [W-1:0]  hw;
  logic          hdir;
  logic [CW-1:0] hcnt;
  logic [7:0]    stream;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d, input logic dr, input logic [CW-1:0] c);
    for (int i = W - 1; i >= 0; i--) q.push_back({1'b1, 1'b0, 1'b1, 1'b0, d[i]});
    for (int k = 0; k < int'(c); k++) q.push_back({1'b1, 1'b0, 1'b0, dr, 1'b0});
    q.push_back(5'b11000);
  endtask

  // Called at a negedge: check current outputs, drive inputs, advance one edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                      input logic dr, input logic [CW-1:0] c);
    logic [4:0] exp_o;
    logic popped, rdy;
    popped = (q.size() != 0);
    exp_o  = popped ? q.pop_front() : 5'b0;
    chk("outs", {busy, done, load, shiftR, d_in}, {3'b0, exp_o});
    chk("excl", {7'b0, load & shiftR}, 8'h0);
    if (load === 1'b1) stream = {stream[6:0], d_in};
    rdy = HOLD ? !held : !popped;
    reset = r;
    up_if.in_valid = v;
    up_if.in_data = d;
    up_if.in_dir = dr;
    up_if.shift_count = c;
    #1;
    chk("ready", {7'b0, up_if.in_ready}, {7'b0, (r ? 1'b0 : rdy)});
    if (HOLD && popped && q.size() == 0 && held) begin
      push_word(hw, hdir, hcnt);
      held = 1'b0;
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      held = 1'b0;
    end else if (v && rdy) begin
      if (!popped || q.size() == 0) push_word(d, dr, c);
      else begin
        held = 1'b1; hw = d; hdir = dr; hcnt = c;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, W'($urandom), 1'b0, CW'($urandom));
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || held) && n < 60) begin
      idle_step();
      n++;
    end
    chk("drain", {7'b0, (n < 60)}, 8'h1);
  endtask

  // Accepts one word from idle and returns cycles from acceptance to done.
  task automatic run_word(input logic [W-1:0] d, input logic dr, input logic [CW-1:0] c,
                          output int lat);
    drain();
    step(1'b0, 1'b1, d, dr, c);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      idle_step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    held = 1'b0;
    stream = '0;
    reset = 1'b1;
    up_if.in_valid = 1'b0;
    up_if.in_data = '0;
    up_if.in_dir = 1'b0;
    up_if.shift_count = '0;
    @(negedge clk);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 4'hA, 1'b1, 4'h2);
    repeat (5) idle_step();

    stream = '0;
    run_word(4'b1110, 1'b1, 4'd0, lat);
    chk("lat_basic", 8'(lat), 8'd5);
    chk("str_basic", stream, 8'h0E);

    stream = '0;
    run_word(4'b1011, 1'b1, 4'd3, lat);
    chk("lat_shr", 8'(lat), 8'd8);
    chk("str_shr", stream, 8'h0B);

    run_word(4'b0101, 1'b0, 4'hF, lat);
    chk("lat_max", 8'(lat), 8'd20);

    // Reset during the second LOAD cycle.
    drain();
    step(1'b0, 1'b1, 4'hC, 1'b1, 4'd2);
    idle_step();
    step(1'b1, 1'b0, 4'h3, 1'b0, 4'd1);
    chk("rst_busy", {7'b0, busy}, 8'h0);
    repeat (8) idle_step();

`ifdef SHIFT_REG_FEEDER_HOLD_EN
    drain();
    stream = '0;
    step(1'b0, 1'b1, 4'h9, 1'b1, 4'd1);
    step(1'b0, 1'b1, 4'h6, 1'b1, 4'd1);
    repeat (16) idle_step();
    chk("str_b2b", stream, 8'h96);
`endif

    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0),
           W'($urandom), 1'($urandom), CW'($urandom));
    end
    drain();
    idle_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
